// File: rtl/pdu_hex_dump.sv
// Streams a window of the PDU buffer to uart_tx as uppercase hex text,
// space-separated with CR/LF after every BPL bytes and after the last byte.
module pdu_hex_dump #(
    parameter int unsigned BPL = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic [7:0] len,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StRd    = 4'd1;
    localparam logic [3:0] StLatch = 4'd2;
    localparam logic [3:0] StHi    = 4'd3;
    localparam logic [3:0] StLo    = 4'd4;
    localparam logic [3:0] StSep   = 4'd5;
    localparam logic [3:0] StCr    = 4'd6;
    localparam logic [3:0] StLf    = 4'd7;
    localparam logic [3:0] StFin   = 4'd8;

    localparam logic [7:0] LastCol = 8'(BPL - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] col_q, col_d;
    logic [7:0] byte_q, byte_d;

    logic tx_ok;
    logic last_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // uart_tx raises busy one cycle late, so the cycle after a pulse is blocked too.
    assign tx_ok     = !tx_busy && !tx_start_q;
    assign last_byte = (cnt_q == len_q - 8'd1);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_d      = len_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        byte_d     = byte_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d  = len;
                    cnt_d  = 8'd0;
                    col_d  = 8'd0;
                    busy_d = 1'b1;
                    if (len == 8'd0) begin
                        state_d = StFin;
                    end else begin
                        mem_addr_d = base_addr;
                        state_d    = StRd;
                    end
                end
            end
            StRd:    state_d = StLatch;
            StLatch: begin
                byte_d  = mem_rdata;
                state_d = StHi;
            end
            StHi: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hex_char(byte_q[7:4]);
                    state_d    = StLo;
                end
            end
            StLo: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hex_char(byte_q[3:0]);
                    state_d    = StSep;
                end
            end
            StSep: begin
                if (last_byte || col_q == LastCol) begin
                    state_d = StCr;
                end else if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h20;
                    cnt_d      = cnt_q + 8'd1;
                    col_d      = col_q + 8'd1;
                    mem_addr_d = mem_addr_q + 8'd1;
                    state_d    = StRd;
                end
            end
            StCr: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h0D;
                    state_d    = StLf;
                end
            end
            StLf: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h0A;
                    // New line starts at column 0 for the next byte.
                    col_d      = 8'd0;
                    if (last_byte) begin
                        state_d = StFin;
                    end else begin
                        cnt_d      = cnt_q + 8'd1;
                        mem_addr_d = mem_addr_q + 8'd1;
                        state_d    = StRd;
                    end
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_addr_q <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            col_q      <= 8'd0;
            byte_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            byte_q     <= byte_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pdu_hex_dump.sv
// Randomized bench for pdu_hex_dump: buffer and uart_tx models plus a text-level
// reference that formats the expected dump straight from the buffer contents.
module tb_pdu_hex_dump;

    localparam int BPL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'd0;
    logic [7:0] len = 8'd0;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int busy_cnt = 0;
    logic force_busy = 1'b0;
    logic prev_start = 1'b0;
    int done_cnt = 0;
    int consec_cnt = 0;
    int busy_viol = 0;
    int vectors = 0;
    int miscompares = 0;

    pdu_hex_dump #(.BPL(BPL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // uart_tx model: busy rises the cycle after tx_start and lasts 1..4 cycles.
    assign tx_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            rx_q.push_back(tx_data);
            busy_cnt <= 1 + $urandom_range(0, 3);
            if (prev_start) consec_cnt <= consec_cnt + 1;
            if (tx_busy) busy_viol <= busy_viol + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        prev_start <= tx_start;
    end

    function automatic logic [7:0] hex_ref(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    function automatic void build_exp(input int b, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int v = mem[(b + i) % 256];
            exp_q.push_back(hex_ref(v / 16));
            exp_q.push_back(hex_ref(v % 16));
            if (i == n - 1 || (i % BPL) == BPL - 1) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(8'h20);
            end
        end
    endfunction

    task automatic kick(input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        base_addr = b;
        len = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int c = 0; c < 30000 && done_cnt == d0; c++) @(negedge clk);
        vectors++;
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL %s_timeout: done never seen, required a done pulse", name);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (mem_addr !== 8'd0) begin miscompares++; $display("FAIL rst_mem_addr got %h exp 00", mem_addr); end
        if (tx_data !== 8'd0) begin miscompares++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start got %b exp 0", tx_start); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pdu();
        string hello = "Hello NVMe/TCP!";
        string lit = {"01 00 00 01 00 00 00 01\x0D\x0A", "48 65 6C 6C 6F 20 4E 56\x0D\x0A",
                      "4D 65 2F 54 43 50 21\x0D\x0A"};
        logic [7:0] hdr [8] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        int d0;
        for (int i = 0; i < 8; i++) mem[i] = hdr[i];
        for (int i = 0; i < hello.len(); i++) mem[8 + i] = hello[i];
        rx_q.delete();
        d0 = done_cnt;
        kick(8'h00, 8'd23);
        wait_done(d0, "pdu");
        repeat (20) @(negedge clk);
        vectors += 2;
        if (rx_q.size() !== 72) begin miscompares++; $display("FAIL pdu_count got %0d exp 72", rx_q.size()); end
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL pdu_done got %0d exp 1", done_cnt - d0); end
        for (int i = 0; i < lit.len() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== lit[i]) begin
                miscompares++;
                $display("FAIL pdu_char[%0d] got %h exp %h", i, rx_q[i], lit[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        int d0 = done_cnt;
        rx_q.delete();
        @(negedge clk);
        len = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy1 got %b exp 1", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done1 got %b exp 0", done); end
        @(negedge clk);
        vectors += 2;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done2 got %b exp 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy2 got %b exp 0", busy); end
        @(negedge clk);
        repeat (10) @(negedge clk);
        vectors += 2;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt - d0); end
        if (rx_q.size() !== 0) begin miscompares++; $display("FAIL zero_tx got %0d exp 0", rx_q.size()); end
    endtask

    task automatic test_wrap();
        string lit = "AB CD EF\x0D\x0A";
        logic [7:0] addr_q[$];
        logic [7:0] exp_addr [3] = '{8'hFE, 8'hFF, 8'h00};
        int d0 = done_cnt;
        mem[8'hFE] = 8'hAB;
        mem[8'hFF] = 8'hCD;
        mem[8'h00] = 8'hEF;
        rx_q.delete();
        kick(8'hFE, 8'd3);
        addr_q.push_back(mem_addr);
        for (int c = 0; c < 2000 && done_cnt == d0; c++) begin
            @(negedge clk);
            if (mem_addr !== addr_q[$]) addr_q.push_back(mem_addr);
        end
        wait_done(d0, "wrap");
        vectors += 2;
        if (addr_q.size() !== 3) begin miscompares++; $display("FAIL wrap_addr_n got %0d exp 3", addr_q.size()); end
        if (rx_q.size() !== 10) begin miscompares++; $display("FAIL wrap_count got %0d exp 10", rx_q.size()); end
        for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
            vectors++;
            if (addr_q[i] !== exp_addr[i]) begin
                miscompares++;
                $display("FAIL wrap_addr[%0d] got %h exp %h", i, addr_q[i], exp_addr[i]);
            end
        end
        for (int i = 0; i < lit.len() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== lit[i]) begin
                miscompares++;
                $display("FAIL wrap_char[%0d] got %h exp %h", i, rx_q[i], lit[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int b = $urandom_range(0, 255);
        int n = $urandom_range(10, 40);
        int d0 = done_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        build_exp(b, n);
        rx_q.delete();
        kick(8'(b), 8'(n));
        repeat (40) @(negedge clk);
        kick(8'(b + 7), 8'(n + 5));
        wait_done(d0, "restart");
        repeat (50) @(negedge clk);
        vectors += 2;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL restart_done got %0d exp 1", done_cnt - d0); end
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL restart_count got %0d exp %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL restart_char[%0d] got %h exp %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int b = $urandom_range(0, 255);
        int d0 = done_cnt;
        int sz;
        int v0 = busy_viol;
        build_exp(b, 20);
        rx_q.delete();
        kick(8'(b), 8'd20);
        for (int c = 0; c < 2000 && !(rx_q.size() >= 7 && !tx_start); c++) @(negedge clk);
        force_busy = 1'b1;
        sz = rx_q.size();
        repeat (1000) @(negedge clk);
        vectors++;
        if (rx_q.size() !== sz) begin miscompares++; $display("FAIL stall_sent got %0d exp %0d", rx_q.size(), sz); end
        force_busy = 1'b0;
        wait_done(d0, "stall");
        vectors += 3;
        if (busy_viol - v0 !== 0) begin miscompares++; $display("FAIL stall_viol got %0d exp 0", busy_viol - v0); end
        if (consec_cnt !== 0) begin miscompares++; $display("FAIL stall_consec got %0d exp 0", consec_cnt); end
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_count got %0d exp %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stall_char[%0d] got %h exp %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b = $urandom_range(0, 255);
        int n = $urandom_range(5, 30);
        int d0;
        rx_q.delete();
        kick(8'(b), 8'd12);
        for (int c = 0; c < 2000 && !(tx_start && rx_q.size() == 1); c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rmid_tx_start got %b exp 0", tx_start); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rmid_done got %b exp 0", done); end
        if (mem_addr !== 8'd0) begin miscompares++; $display("FAIL rmid_mem_addr got %h exp 00", mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rx_q.delete();
        build_exp(b, n);
        d0 = done_cnt;
        kick(8'(b), 8'(n));
        wait_done(d0, "rmid");
        vectors++;
        if (rx_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rmid_count got %0d exp %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rmid_char[%0d] got %h exp %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int b = $urandom_range(0, 255);
            int n = (t == 0) ? 255 : $urandom_range(1, 60);
            int d0 = done_cnt;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            build_exp(b, n);
            rx_q.delete();
            kick(8'(b), 8'(n));
            wait_done(d0, "rand");
            vectors++;
            if (rx_q.size() !== exp_q.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count got %0d exp %0d", t, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                vectors++;
                if (rx_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_char[%0d] got %h exp %h", t, i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pdu();
        test_len_zero();
        test_wrap();
        test_restart_ignored();
        test_stall();
        test_reset_mid();
        test_random();
        vectors++;
        if (consec_cnt !== 0) begin miscompares++; $display("FAIL consec_total got %0d exp 0", consec_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
